// File: rtl/xswitch_egress_buffer.sv
// rtl/xswitch_egress_buffer.sv - egress FIFO for one xswitch output port with address filtering
module xswitch_egress_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int PORT_ID    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    data_out,
    input  logic [ADDR_WIDTH-1:0]    addr_out,
    input  logic                     data_rdy,
    output logic                     data_read,
    output logic                     rcv_rdy,
    output logic                     m_valid,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic [ADDR_WIDTH-1:0]    m_addr,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               misroute_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [CW-1:0]         FULL_LEVEL = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] OWN_ADDR   = ADDR_WIDTH'(PORT_ID);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [EW-1:0]   mem [DEPTH];

    logic accept;
    logic push;
    logic misroute;
    logic pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The ACK cycle is mandatory so a single presentation is never taken twice.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (data_rdy && rcv_rdy) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        data_read = 1'b0;
        rcv_rdy   = 1'b0;
        case (state)
            S_IDLE:  rcv_rdy   = !reset && (count < FULL_LEVEL);
            S_ACK:   data_read = 1'b1;
            default: begin
                data_read = 1'b0;
                rcv_rdy   = 1'b0;
            end
        endcase
    end

    assign accept   = (state == S_IDLE) && data_rdy && rcv_rdy;
    assign push     = accept && (addr_out == OWN_ADDR);
    assign misroute = accept && (addr_out != OWN_ADDR);

    assign m_valid  = (count != '0);
    assign pop      = m_valid && m_ready;
    assign {m_addr, m_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {addr_out, data_out};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misroute_cnt <= 8'd0;
        end else if (misroute && (misroute_cnt != 8'hFF)) begin
            misroute_cnt <= misroute_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_xswitch_egress_buffer.sv
// tb/tb_xswitch_egress_buffer.sv - directed self-checking bench for xswitch_egress_buffer
module tb_xswitch_egress_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_out = 8'h00;
    logic [1:0] addr_out = 2'd0;

    logic       rdy_a = 1'b0, mready_a = 1'b0;
    logic       a_data_read, a_rcv_rdy, a_m_valid;
    logic [7:0] a_m_data, a_misroute_cnt;
    logic [1:0] a_m_addr;
    logic [2:0] a_count;

    logic       rdy_b = 1'b0, mready_b = 1'b0;
    logic       b_data_read, b_rcv_rdy, b_m_valid;
    logic [7:0] b_m_data, b_misroute_cnt;
    logic [1:0] b_m_addr;
    logic [2:0] b_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xswitch_egress_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .PORT_ID(2)) u_dut_a (
        .clk(clk), .reset(reset), .data_out(data_out), .addr_out(addr_out),
        .data_rdy(rdy_a), .data_read(a_data_read), .rcv_rdy(a_rcv_rdy),
        .m_valid(a_m_valid), .m_data(a_m_data), .m_addr(a_m_addr), .m_ready(mready_a),
        .count(a_count), .misroute_cnt(a_misroute_cnt)
    );

    xswitch_egress_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .PORT_ID(1)) u_dut_b (
        .clk(clk), .reset(reset), .data_out(data_out), .addr_out(addr_out),
        .data_rdy(rdy_b), .data_read(b_data_read), .rcv_rdy(b_rcv_rdy),
        .m_valid(b_m_valid), .m_data(b_m_data), .m_addr(b_m_addr), .m_ready(mready_b),
        .count(b_count), .misroute_cnt(b_misroute_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one word to instance B and waits (bounded) for its acknowledge.
    task automatic send_b(input logic [7:0] d, input logic [1:0] a);
        int k;
        logic got;
        data_out = d;
        addr_out = a;
        rdy_b    = 1'b1;
        got      = 1'b0;
        k        = 0;
        while (!got && k < 20) begin
            step();
            if (b_data_read) got = 1'b1;
            k++;
        end
        rdy_b = 1'b0;
        chk("send_ack", {31'd0, got}, 32'd1);
    endtask

    initial begin
        int nw, np, cyc;

        // Reset state
        step();
        chk("rst_data_read", {31'd0, a_data_read}, 32'd0);
        chk("rst_rcv_rdy",   {31'd0, a_rcv_rdy},   32'd0);
        chk("rst_m_valid",   {31'd0, a_m_valid},   32'd0);
        chk("rst_count",     {29'd0, a_count},     32'd0);
        chk("rst_misroute",  {24'd0, a_misroute_cnt}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_rcv_rdy", {31'd0, a_rcv_rdy}, 32'd1);

        // Single word on PORT_ID=2
        data_out = 8'hA5;
        addr_out = 2'd2;
        rdy_a    = 1'b1;
        step();
        chk("t1_data_read", {31'd0, a_data_read}, 32'd1);
        chk("t1_m_valid",   {31'd0, a_m_valid},   32'd1);
        chk("t1_m_data",    {24'd0, a_m_data},    32'hA5);
        chk("t1_m_addr",    {30'd0, a_m_addr},    32'd2);
        chk("t1_count",     {29'd0, a_count},     32'd1);
        rdy_a    = 1'b0;
        mready_a = 1'b1;
        step();
        chk("t1_read_pulse", {31'd0, a_data_read}, 32'd0);
        chk("t1_count_pop",  {29'd0, a_count},     32'd0);
        mready_a = 1'b0;

        // Fill and backpressure on PORT_ID=1
        send_b(8'h01, 2'd1);
        send_b(8'h02, 2'd1);
        send_b(8'h03, 2'd1);
        send_b(8'h04, 2'd1);
        step();
        chk("t2_count_full", {29'd0, b_count},   32'd4);
        chk("t2_rcv_rdy0",   {31'd0, b_rcv_rdy}, 32'd0);
        data_out = 8'h05;
        addr_out = 2'd1;
        rdy_b    = 1'b1;
        step();
        chk("t2_no_ack1", {31'd0, b_data_read}, 32'd0);
        step();
        chk("t2_no_ack2", {31'd0, b_data_read}, 32'd0);
        chk("t2_head01",  {24'd0, b_m_data},    32'h01);
        mready_b = 1'b1;
        step();
        mready_b = 1'b0;
        chk("t2_head02",  {24'd0, b_m_data},    32'h02);
        chk("t2_count3",  {29'd0, b_count},     32'd3);
        chk("t2_rcv_rdy1", {31'd0, b_rcv_rdy},  32'd1);
        chk("t2_no_ack3", {31'd0, b_data_read}, 32'd0);
        step();
        chk("t2_ack05",   {31'd0, b_data_read}, 32'd1);
        chk("t2_count4",  {29'd0, b_count},     32'd4);
        rdy_b = 1'b0;
        step();
        mready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain", {24'd0, b_m_data}, 32'h02 + i);
            step();
        end
        mready_b = 1'b0;
        chk("t2_empty", {29'd0, b_count}, 32'd0);

        // Wrap-around with random sink readiness
        nw = 0;
        np = 0;
        cyc = 0;
        while (np < 10 && cyc < 300) begin
            if (nw < 10) begin
                data_out = 8'h10 + 8'(nw);
                addr_out = 2'd1;
                rdy_b    = 1'b1;
            end else begin
                rdy_b = 1'b0;
            end
            mready_b = 1'($urandom_range(0, 1));
            if (b_m_valid && mready_b) begin
                chk("t3_order", {24'd0, b_m_data}, 32'h10 + np);
                np++;
            end
            step();
            cyc++;
            if (b_data_read) begin
                nw++;
                rdy_b = 1'b0;
            end
        end
        mready_b = 1'b0;
        rdy_b    = 1'b0;
        chk("t3_popped", np, 32'd10);
        chk("t3_pushed", nw, 32'd10);
        chk("t3_empty",  {29'd0, b_count}, 32'd0);
        step();

        // Misroute drop and saturation
        send_b(8'h77, 2'd3);
        chk("t4_count0",   {29'd0, b_count},        32'd0);
        chk("t4_misroute", {24'd0, b_misroute_cnt}, 32'd1);
        for (int i = 0; i < 254; i++) begin
            send_b(8'(i), 2'd3);
        end
        chk("t4_mis255",  {24'd0, b_misroute_cnt}, 32'd255);
        send_b(8'hEE, 2'd0);
        chk("t4_mis_sat", {24'd0, b_misroute_cnt}, 32'd255);
        chk("t4_count_still0", {29'd0, b_count},   32'd0);

        // Simultaneous push and pop
        send_b(8'h21, 2'd1);
        send_b(8'h22, 2'd1);
        step();
        chk("t5_count2", {29'd0, b_count}, 32'd2);
        data_out = 8'h23;
        addr_out = 2'd1;
        rdy_b    = 1'b1;
        mready_b = 1'b1;
        step();
        rdy_b    = 1'b0;
        mready_b = 1'b0;
        chk("t5_ack",       {31'd0, b_data_read}, 32'd1);
        chk("t5_count_eq",  {29'd0, b_count},     32'd2);
        chk("t5_head",      {24'd0, b_m_data},    32'h22);

        // Asynchronous reset during ACK with three words held
        send_b(8'h24, 2'd1);
        chk("t6_count3", {29'd0, b_count}, 32'd3);
        reset = 1'b1;
        #2;
        chk("t6_data_read", {31'd0, b_data_read}, 32'd0);
        chk("t6_m_valid",   {31'd0, b_m_valid},   32'd0);
        chk("t6_rcv_rdy",   {31'd0, b_rcv_rdy},   32'd0);
        chk("t6_count",     {29'd0, b_count},     32'd0);
        chk("t6_misroute",  {24'd0, b_misroute_cnt}, 32'd0);
        step();
        reset = 1'b0;
        send_b(8'h5A, 2'd1);
        chk("t6_first_out", {24'd0, b_m_data},  32'h5A);
        chk("t6_valid",     {31'd0, b_m_valid}, 32'd1);
        chk("t6_count1",    {29'd0, b_count},   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
